// File: rtl/gemm_cmd_pkg.sv
// ============================================================================
// Module  : gemm_cmd_pkg
// Purpose : Shared types for the GEMM custom-instruction responder.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package gemm_cmd_pkg;

  localparam logic [6:0] C_GEMM_OPC_DEFAULT = 7'b0001011;
  localparam int         C_DIM_MAX_W        = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Encoding equals funct3, so a legal opcode decodes by a plain cast.
  typedef enum logic [2:0] {
    CMD_SET_A   = 3'd0,
    CMD_SET_B   = 3'd1,
    CMD_SET_C   = 3'd2,
    CMD_SET_MN  = 3'd3,
    CMD_SET_K   = 3'd4,
    CMD_START   = 3'd5,
    CMD_CLR_ERR = 3'd6,
    CMD_ILLEGAL = 3'd7
  } cmd_t;

  typedef struct packed {
    logic [31:0]            a_base;
    logic [31:0]            b_base;
    logic [31:0]            c_base;
    logic [C_DIM_MAX_W-1:0] m;
    logic [C_DIM_MAX_W-1:0] n;
    logic [C_DIM_MAX_W-1:0] k;
  } gemm_desc_t;

endpackage

`default_nettype wire

// File: rtl/gemm_cmd_decode.sv
// ============================================================================
// Module  : gemm_cmd_decode
// Purpose : Combinational instruction word to command decode.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module gemm_cmd_decode
  import gemm_cmd_pkg::*;
#(
  parameter logic [6:0] GEMM_OPC = C_GEMM_OPC_DEFAULT
) (
  input  logic [31:0] instruction,
  output cmd_t        cmd
);

  always_comb begin
    cmd = CMD_ILLEGAL;
    if (instruction[6:0] == GEMM_OPC) begin
      cmd = cmd_t'(instruction[14:12]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/gemm_cmd_responder.sv
// ============================================================================
// Module  : gemm_cmd_responder
// Purpose : GEMM command endpoint: descriptor registers plus backend launch
//           FSM. Optional watchdog enabled by macro GEMM_TIMEOUT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module gemm_cmd_responder
  import gemm_cmd_pkg::*;
#(
  parameter int         DIM_W       = 16,
  parameter logic [6:0] GEMM_OPC    = C_GEMM_OPC_DEFAULT,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gemm_valid,
  input  logic [31:0]      gemm_instruction,
  input  logic [31:0]      gemm_rdata1,
  input  logic [31:0]      gemm_rdata2,
  output logic             gemm_done,
  output logic             acc_start,
  input  logic             acc_ready,
  input  logic             acc_done,
  output logic [31:0]      acc_a_base,
  output logic [31:0]      acc_b_base,
  output logic [31:0]      acc_c_base,
  output logic [DIM_W-1:0] acc_m,
  output logic [DIM_W-1:0] acc_n,
  output logic [DIM_W-1:0] acc_k,
  output logic             busy,
  output logic             err
);

  state_t     r_state;
  state_t     w_next;
  cmd_t       w_cmd;
  gemm_desc_t r_desc;
  logic       r_gemm_done;
  logic       r_acc_start;
  logic       r_err;
  logic       w_accept;
  logic       w_dim_zero;
  logic       w_timeout;

  gemm_cmd_decode #(
    .GEMM_OPC    (GEMM_OPC)
  ) u_decode (
    .instruction (gemm_instruction),
    .cmd         (w_cmd)
  );

  assign w_accept   = (r_state == ST_IDLE) && gemm_valid;
  assign w_dim_zero = (r_desc.m == '0) || (r_desc.n == '0) || (r_desc.k == '0);

`ifdef GEMM_TIMEOUT_EN
  localparam int C_TMO_W = $clog2(TIMEOUT_CYC);

  logic [C_TMO_W-1:0] r_tmo_cnt;

  // Cleared while idle, so every launch starts from zero; one budget covers
  // the whole ISSUE+BUSY span.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == ST_ISSUE) || (r_state == ST_BUSY)) begin
      r_tmo_cnt <= r_tmo_cnt + C_TMO_W'(1);
    end
  end

  assign w_timeout = (((r_state == ST_ISSUE) && !acc_ready) ||
                      ((r_state == ST_BUSY)  && !acc_done)) &&
                     (r_tmo_cnt == C_TMO_W'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if ((w_cmd == CMD_START) && !w_dim_zero) w_next = ST_ISSUE;
          else                                     w_next = ST_DONE;
        end
      end
      ST_ISSUE: begin
        if (acc_ready)      w_next = ST_BUSY;
        else if (w_timeout) w_next = ST_DONE;
      end
      ST_BUSY: begin
        if (acc_done)       w_next = ST_DONE;
        else if (w_timeout) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Handshake outputs come straight from flops, timed off the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gemm_done <= 1'b0;
      r_acc_start <= 1'b0;
    end else begin
      r_gemm_done <= (w_next == ST_DONE);
      r_acc_start <= (w_next == ST_ISSUE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_desc <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        case (w_cmd)
          CMD_SET_A:   r_desc.a_base <= gemm_rdata1;
          CMD_SET_B:   r_desc.b_base <= gemm_rdata1;
          CMD_SET_C:   r_desc.c_base <= gemm_rdata1;
          CMD_SET_MN: begin
            r_desc.m <= C_DIM_MAX_W'(gemm_rdata1[DIM_W-1:0]);
            r_desc.n <= C_DIM_MAX_W'(gemm_rdata2[DIM_W-1:0]);
          end
          CMD_SET_K:   r_desc.k <= C_DIM_MAX_W'(gemm_rdata1[DIM_W-1:0]);
          CMD_START:   if (w_dim_zero) r_err <= 1'b1;
          CMD_CLR_ERR: r_err <= 1'b0;
          default:     r_err <= 1'b1;
        endcase
      end
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign gemm_done  = r_gemm_done;
  assign acc_start  = r_acc_start;
  assign busy       = (r_state != ST_IDLE);
  assign err        = r_err;
  assign acc_a_base = r_desc.a_base;
  assign acc_b_base = r_desc.b_base;
  assign acc_c_base = r_desc.c_base;
  assign acc_m      = r_desc.m[DIM_W-1:0];
  assign acc_n      = r_desc.n[DIM_W-1:0];
  assign acc_k      = r_desc.k[DIM_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_gemm_cmd_responder.sv
// ============================================================================
// Module  : tb_gemm_cmd_responder
// Purpose : Directed bench for gemm_cmd_responder; timeout section is built
//           only with GEMM_TIMEOUT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gemm_cmd_responder;

  localparam int         DIM_W = 16;
  localparam int         TMO   = 16;
  localparam logic [6:0] OPC   = 7'b0001011;

  logic             clk;
  logic             rst;
  logic             gemm_valid;
  logic [31:0]      gemm_instruction;
  logic [31:0]      gemm_rdata1;
  logic [31:0]      gemm_rdata2;
  logic             gemm_done;
  logic             acc_start;
  logic             acc_ready;
  logic             acc_done;
  logic [31:0]      acc_a_base;
  logic [31:0]      acc_b_base;
  logic [31:0]      acc_c_base;
  logic [DIM_W-1:0] acc_m;
  logic [DIM_W-1:0] acc_n;
  logic [DIM_W-1:0] acc_k;
  logic             busy;
  logic             err;

  int n_cmp  = 0;
  int n_fail = 0;

  gemm_cmd_responder #(
    .DIM_W            (DIM_W),
    .GEMM_OPC         (OPC),
    .TIMEOUT_CYC      (TMO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .gemm_valid       (gemm_valid),
    .gemm_instruction (gemm_instruction),
    .gemm_rdata1      (gemm_rdata1),
    .gemm_rdata2      (gemm_rdata2),
    .gemm_done        (gemm_done),
    .acc_start        (acc_start),
    .acc_ready        (acc_ready),
    .acc_done         (acc_done),
    .acc_a_base       (acc_a_base),
    .acc_b_base       (acc_b_base),
    .acc_c_base       (acc_c_base),
    .acc_m            (acc_m),
    .acc_n            (acc_n),
    .acc_k            (acc_k),
    .busy             (busy),
    .err              (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [15:0] m;
    logic [15:0] n;
    logic [15:0] k;
    logic        e;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mkv(logic [6:0] opc, logic [2:0] f3, logic [31:0] rd1,
                               logic [31:0] rd2, logic [31:0] a, logic [31:0] b,
                               logic [31:0] c, logic [15:0] m, logic [15:0] n,
                               logic [15:0] k, logic e);
    vec_t v;
    v.opc = opc; v.f3 = f3; v.rd1 = rd1; v.rd2 = rd2;
    v.a = a; v.b = b; v.c = c; v.m = m; v.n = n; v.k = k; v.e = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive_cmd(input logic [6:0] opc, input logic [2:0] f3,
                           input logic [31:0] r1, input logic [31:0] r2);
    gemm_instruction = {17'd0, f3, 5'd0, opc};
    gemm_rdata1      = r1;
    gemm_rdata2      = r2;
    gemm_valid       = 1'b1;
  endtask

  // Runs one command that needs no backend; valid drops once done is seen,
  // then two trailing cycles catch any extra pulse or lingering busy.
  task automatic run_cmd(input logic [6:0] opc, input logic [2:0] f3,
                         input logic [31:0] r1, input logic [31:0] r2,
                         output int lat, output int nd, output int nb, output int ns);
    lat = -1; nd = 0; nb = 0; ns = 0;
    drive_cmd(opc, f3, r1, r2);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (busy) nb++;
      if (acc_start) ns++;
      if (gemm_done) begin
        nd++;
        lat = c;
        break;
      end
    end
    gemm_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      if (busy) nb++;
      if (gemm_done) nd++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int lat, nd, nb, ns, cnt;
    logic ok;

    vecs[0]  = mkv(OPC,        3'd0, 32'h0000_1000, 32'h0, 32'h1000, 32'h0,    32'h0,    16'd0, 16'd0, 16'd0, 1'b0);
    vecs[1]  = mkv(OPC,        3'd1, 32'h0000_2000, 32'h0, 32'h1000, 32'h2000, 32'h0,    16'd0, 16'd0, 16'd0, 1'b0);
    vecs[2]  = mkv(OPC,        3'd2, 32'h0000_3000, 32'h0, 32'h1000, 32'h2000, 32'h3000, 16'd0, 16'd0, 16'd0, 1'b0);
    vecs[3]  = mkv(OPC,        3'd3, 32'hABCD_0004, 32'h1234_0004, 32'h1000, 32'h2000, 32'h3000, 16'd4, 16'd4, 16'd0, 1'b0);
    vecs[4]  = mkv(OPC,        3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1000, 32'h2000, 32'h3000, 16'd4, 16'd4, 16'd0, 1'b1);
    vecs[5]  = mkv(OPC,        3'd6, 32'h0,         32'h0, 32'h1000, 32'h2000, 32'h3000, 16'd4, 16'd4, 16'd0, 1'b0);
    vecs[6]  = mkv(7'b0110011, 3'd0, 32'h0000_DEAD, 32'h0, 32'h1000, 32'h2000, 32'h3000, 16'd4, 16'd4, 16'd0, 1'b1);
    vecs[7]  = mkv(OPC,        3'd6, 32'h0,         32'h0, 32'h1000, 32'h2000, 32'h3000, 16'd4, 16'd4, 16'd0, 1'b0);
    vecs[8]  = mkv(OPC,        3'd5, 32'h0,         32'h0, 32'h1000, 32'h2000, 32'h3000, 16'd4, 16'd4, 16'd0, 1'b1);
    vecs[9]  = mkv(OPC,        3'd6, 32'h0,         32'h0, 32'h1000, 32'h2000, 32'h3000, 16'd4, 16'd4, 16'd0, 1'b0);
    vecs[10] = mkv(OPC,        3'd4, 32'h0005_0008, 32'h0, 32'h1000, 32'h2000, 32'h3000, 16'd4, 16'd4, 16'd8, 1'b0);

    rst = 1'b0; gemm_valid = 1'b0; gemm_instruction = '0;
    gemm_rdata1 = '0; gemm_rdata2 = '0; acc_ready = 1'b0; acc_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",      32'(busy),      32'd0);
    chk("reset_done",      32'(gemm_done), 32'd0);
    chk("reset_acc_start", 32'(acc_start), 32'd0);
    chk("reset_err",       32'(err),       32'd0);
    chk("reset_a_base",    acc_a_base,     32'd0);
    chk("reset_k",         32'(acc_k),     32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      run_cmd(vecs[i].opc, vecs[i].f3, vecs[i].rd1, vecs[i].rd2, lat, nd, nb, ns);
      chk($sformatf("v%0d_latency",   i), 32'(lat),       32'd1);
      chk($sformatf("v%0d_done_cnt",  i), 32'(nd),        32'd1);
      chk($sformatf("v%0d_busy_cnt",  i), 32'(nb),        32'd1);
      chk($sformatf("v%0d_start_cnt", i), 32'(ns),        32'd0);
      chk($sformatf("v%0d_a_base",    i), acc_a_base,     vecs[i].a);
      chk($sformatf("v%0d_b_base",    i), acc_b_base,     vecs[i].b);
      chk($sformatf("v%0d_c_base",    i), acc_c_base,     vecs[i].c);
      chk($sformatf("v%0d_m",         i), 32'(acc_m),     32'(vecs[i].m));
      chk($sformatf("v%0d_n",         i), 32'(acc_n),     32'(vecs[i].n));
      chk($sformatf("v%0d_k",         i), 32'(acc_k),     32'(vecs[i].k));
      chk($sformatf("v%0d_err",       i), 32'(err),       32'(vecs[i].e));
    end

    // Full launch: ready low for three start cycles, done ten cycles into BUSY.
    drive_cmd(OPC, 3'd5, 32'h0, 32'h0);
    cnt = 0; ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (acc_start) cnt++;
      if (gemm_done || acc_m != 16'd4 || acc_n != 16'd4 || acc_k != 16'd8) ok = 1'b0;
      if (c == 3) acc_ready = 1'b1;
    end
    @(posedge clk); #1;
    acc_ready = 1'b0;
    chk("launch_start_cycles", 32'(cnt),       32'd4);
    chk("launch_start_drop",   32'(acc_start), 32'd0);
    chk("launch_busy",         32'(busy),      32'd1);
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      if (gemm_done || acc_start || !busy) ok = 1'b0;
      if (acc_m != 16'd4 || acc_n != 16'd4 || acc_k != 16'd8) ok = 1'b0;
    end
    acc_done = 1'b1;
    @(posedge clk); #1;
    acc_done = 1'b0;
    chk("launch_stable",  32'(ok),        32'd1);
    chk("launch_done",    32'(gemm_done), 32'd1);
    chk("launch_err",     32'(err),       32'd0);
    gemm_valid = 1'b0;
    @(posedge clk); #1;
    chk("launch_done_single", 32'(gemm_done), 32'd0);
    chk("launch_idle",        32'(busy),      32'd0);

    // Reset asserted while the backend is running.
    drive_cmd(OPC, 3'd5, 32'h0, 32'h0);
    @(posedge clk); #1;
    acc_ready = 1'b1;
    @(posedge clk); #1;
    acc_ready = 1'b0;
    chk("rstmid_in_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_busy",      32'(busy),      32'd0);
    chk("rstmid_acc_start", 32'(acc_start), 32'd0);
    chk("rstmid_done",      32'(gemm_done), 32'd0);
    chk("rstmid_a_base",    acc_a_base,     32'd0);
    chk("rstmid_m",         32'(acc_m),     32'd0);
    gemm_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    acc_done = 1'b1;
    @(posedge clk); #1;
    acc_done = 1'b0;
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (gemm_done || busy) cnt++;
    end
    chk("spurious_acc_done", 32'(cnt), 32'd0);

`ifdef GEMM_TIMEOUT_EN
    run_cmd(OPC, 3'd3, 32'd2, 32'd3, lat, nd, nb, ns);
    run_cmd(OPC, 3'd4, 32'd5, 32'd0, lat, nd, nb, ns);
    chk("tmo_k_setup", 32'(acc_k), 32'd5);
    drive_cmd(OPC, 3'd5, 32'h0, 32'h0);
    acc_ready = 1'b1;
    cnt = 0; ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      acc_ready = 1'b0;
      if (gemm_done) begin
        ok = 1'b1;
        break;
      end
      if (busy) cnt++;
    end
    chk("tmo_done_seen", 32'(ok),  32'd1);
    chk("tmo_cycles",    32'(cnt), 32'(TMO));
    chk("tmo_err",       32'(err), 32'd1);
    gemm_valid = 1'b0;
    @(posedge clk); #1;
    acc_done = 1'b1;
    @(posedge clk); #1;
    acc_done = 1'b0;
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (gemm_done || busy) cnt++;
    end
    chk("tmo_late_done", 32'(cnt), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
